// File: rtl/palette_pkg.sv
// Shared widths, payload types and default palette generator for the colour palette block.
package palette_pkg;

    localparam int unsigned IDX_W  = 8;
    localparam int unsigned COMP_W = 3;
    localparam int unsigned RGB_W  = 3 * COMP_W;
    localparam int unsigned DEPTH  = 1 << IDX_W;

    typedef struct packed {
        logic [COMP_W-1:0] r;
        logic [COMP_W-1:0] g;
        logic [COMP_W-1:0] b;
    } rgb_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // Index bits are dealt MSB-first into r, then g, then b; b is left-justified with zero fill.
    function automatic rgb_t default_color(input logic [IDX_W-1:0] idx);
        rgb_t                     c;
        logic [IDX_W+COMP_W-1:0]  ext;
        ext = {idx, COMP_W'(0)};
        c.r = idx[IDX_W-1 -: COMP_W];
        c.g = idx[IDX_W-1-COMP_W -: COMP_W];
        c.b = ext[IDX_W-COMP_W-1 -: COMP_W];
        return c;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// Palette storage: one write port, registered pixel read port and, with
// PALETTE_READBACK_EN, a second registered read port. Reads return pre-write data.
module palette_ram
    import palette_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [RGB_W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr_a,
    output logic [RGB_W-1:0] rdata_a
`ifdef PALETTE_READBACK_EN
    ,
    input  logic             re_b,
    input  logic [IDX_W-1:0] raddr_b,
    output logic [RGB_W-1:0] rdata_b
`endif
);

    logic [RGB_W-1:0] mem [DEPTH];

    // Storage array carries no reset; it is reloaded by the init walker.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_a <= '0;
        end else begin
            rdata_a <= mem[raddr_a];
        end
    end

`ifdef PALETTE_READBACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_b <= '0;
        end else if (re_b) begin
            rdata_b <= mem[raddr_b];
        end
    end
`endif

endmodule

// File: rtl/palette_lut.sv
// Pixel index to RGB lookup with CPU-writable palette and post-reset default load.
// Optional CPU readback port enabled by defining PALETTE_READBACK_EN.
module palette_lut
    import palette_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic [IDX_W-1:0]  pix_idx,
    input  logic              pix_blank,
    output logic              out_valid,
    output logic [COMP_W-1:0] r,
    output logic [COMP_W-1:0] g,
    output logic [COMP_W-1:0] b,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [RGB_W-1:0]  wr_data,
    output logic              init_busy
`ifdef PALETTE_READBACK_EN
    ,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic              rd_valid,
    output logic [RGB_W-1:0]  rd_data
`endif
);

    fsm_t             state_q, state_d;
    logic [IDX_W-1:0] walker_q, walker_d;
    logic             we_c;
    logic [IDX_W-1:0] waddr_c;
    logic [RGB_W-1:0] wdata_c;
    logic             ram_we_c;
    logic [RGB_W-1:0] pix_rgb;
    logic             s1_valid;
    logic             s1_kill;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= INIT;
            walker_q  <= '0;
            init_busy <= 1'b1;
            wr_ready  <= 1'b0;
        end else begin
            state_q   <= state_d;
            walker_q  <= walker_d;
            init_busy <= (state_d == INIT);
            wr_ready  <= (state_d == RUN);
        end
    end

    // Write port is owned by the walker during INIT, by the CPU afterwards.
    always_comb begin
        state_d  = state_q;
        walker_d = walker_q;
        we_c     = 1'b0;
        waddr_c  = wr_addr;
        wdata_c  = wr_data;
        case (state_q)
            INIT: begin
                we_c     = 1'b1;
                waddr_c  = walker_q;
                wdata_c  = default_color(walker_q);
                walker_d = walker_q + 1'b1;
                if (walker_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                we_c = wr_valid;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign ram_we_c = we_c & rst_n;

    palette_ram u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we_c),
        .waddr   (waddr_c),
        .wdata   (wdata_c),
        .raddr_a (pix_idx),
        .rdata_a (pix_rgb)
`ifdef PALETTE_READBACK_EN
        ,
        .re_b    (rd_en & ~init_busy),
        .raddr_b (rd_addr),
        .rdata_b (rd_data)
`endif
    );

    // Stage 1 travels alongside the RAM read; stage 2 applies the black override.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_kill   <= 1'b1;
            out_valid <= 1'b0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
        end else begin
            s1_valid  <= pix_valid;
            s1_kill   <= pix_blank | init_busy | ~pix_valid;
            out_valid <= s1_valid;
            {r, g, b} <= s1_kill ? RGB_W'(0) : pix_rgb;
        end
    end

`ifdef PALETTE_READBACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en & ~init_busy;
        end
    end
`endif

endmodule

// File: tb/tb_palette_lut.sv
// Directed self-checking bench for palette_lut (covers PALETTE_READBACK_EN when defined).
module tb_palette_lut;
    import palette_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pix_valid;
    logic [IDX_W-1:0]  pix_idx;
    logic              pix_blank;
    logic              out_valid;
    logic [COMP_W-1:0] r, g, b;
    logic              wr_valid;
    logic              wr_ready;
    logic [IDX_W-1:0]  wr_addr;
    logic [RGB_W-1:0]  wr_data;
    logic              init_busy;
`ifdef PALETTE_READBACK_EN
    logic              rd_en;
    logic [IDX_W-1:0]  rd_addr;
    logic              rd_valid;
    logic [RGB_W-1:0]  rd_data;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    palette_lut dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_idx   (pix_idx),
        .pix_blank (pix_blank),
        .out_valid (out_valid),
        .r         (r),
        .g         (g),
        .b         (b),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .init_busy (init_busy)
`ifdef PALETTE_READBACK_EN
        ,
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic v, input logic [IDX_W-1:0] idx, input logic blank);
        pix_valid = v;
        pix_idx   = idx;
        pix_blank = blank;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_busy && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        logic rdy_early;
        rst_n = 1'b0;
        tick();
        checks++;
        if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy: got %b expected 1", init_busy); end
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if ({r, g, b} !== 9'h000) begin errors++; $display("FAIL reset_rgb: got %h expected 000", {r, g, b}); end
        rst_n = 1'b1;
        n = 0;
        rdy_early = 1'b0;
        while (init_busy && n < 400) begin
            rdy_early = rdy_early | wr_ready;
            tick();
            n++;
        end
        checks++;
        if (n !== 256) begin errors++; $display("FAIL init_length: got %0d expected 256", n); end
        checks++;
        if (rdy_early !== 1'b0) begin errors++; $display("FAIL wr_ready_during_init: got %b expected 0", rdy_early); end
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_after_init: got %b expected 1", wr_ready); end
    endtask

    task automatic test_init_pixel();
        int n;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_pix(1'b1, 8'hE5, 1'b0);
        tick();
        set_pix(1'b0, 8'h00, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL init_pix_valid: got %b expected 1", out_valid); end
        checks++;
        if ({r, g, b} !== 9'h000) begin errors++; $display("FAIL init_pix_black: got %h expected 000", {r, g, b}); end
        wait_init(n);
        checks++;
        if (init_busy !== 1'b0) begin errors++; $display("FAIL init_pix_timeout: got busy=%b expected 0", init_busy); end
    endtask

    task automatic test_default();
        set_pix(1'b1, 8'hE5, 1'b0);
        tick();
        set_pix(1'b1, 8'hFF, 1'b0);
        tick();
        checks++;
        if ({out_valid, r, g, b} !== {1'b1, 9'h1CA}) begin errors++; $display("FAIL default_E5: got v=%b rgb=%h expected v=1 rgb=1ca", out_valid, {r, g, b}); end
        set_pix(1'b1, 8'h00, 1'b0);
        tick();
        checks++;
        if ({out_valid, r, g, b} !== {1'b1, 9'h1FE}) begin errors++; $display("FAIL default_FF: got v=%b rgb=%h expected v=1 rgb=1fe", out_valid, {r, g, b}); end
        set_pix(1'b0, 8'h00, 1'b0);
        tick();
        checks++;
        if ({out_valid, r, g, b} !== {1'b1, 9'h000}) begin errors++; $display("FAIL default_00: got v=%b rgb=%h expected v=1 rgb=000", out_valid, {r, g, b}); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_write();
        wr_valid = 1'b1;
        wr_addr  = 8'h10;
        wr_data  = 9'h1FF;
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL write_ready: got %b expected 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        set_pix(1'b1, 8'h10, 1'b0);
        tick();
        set_pix(1'b0, 8'h00, 1'b0);
        tick();
        checks++;
        if ({out_valid, r, g, b} !== {1'b1, 9'h1FF}) begin errors++; $display("FAIL write_10: got v=%b rgb=%h expected v=1 rgb=1ff", out_valid, {r, g, b}); end
    endtask

    task automatic test_collision();
        wr_valid = 1'b1;
        wr_addr  = 8'h20;
        wr_data  = 9'h124;
        tick();
        wr_data  = 9'h000;
        set_pix(1'b1, 8'h20, 1'b0);
        tick();
        wr_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, r, g, b} !== {1'b1, 9'h124}) begin errors++; $display("FAIL collision_old: got v=%b rgb=%h expected v=1 rgb=124", out_valid, {r, g, b}); end
        set_pix(1'b0, 8'h00, 1'b0);
        tick();
        checks++;
        if ({out_valid, r, g, b} !== {1'b1, 9'h000}) begin errors++; $display("FAIL collision_new: got v=%b rgb=%h expected v=1 rgb=000", out_valid, {r, g, b}); end
        tick();
    endtask

    task automatic test_back_to_back();
        wr_valid = 1'b1;
        wr_addr  = 8'h40; wr_data = 9'h0AA; tick();
        wr_addr  = 8'h41; wr_data = 9'h155; tick();
        wr_addr  = 8'h40; wr_data = 9'h033; tick();
        wr_valid = 1'b0;
        set_pix(1'b1, 8'h40, 1'b0);
        tick();
        set_pix(1'b1, 8'h41, 1'b0);
        tick();
        checks++;
        if ({out_valid, r, g, b} !== {1'b1, 9'h033}) begin errors++; $display("FAIL b2b_40: got v=%b rgb=%h expected v=1 rgb=033", out_valid, {r, g, b}); end
        set_pix(1'b0, 8'h00, 1'b0);
        tick();
        checks++;
        if ({out_valid, r, g, b} !== {1'b1, 9'h155}) begin errors++; $display("FAIL b2b_41: got v=%b rgb=%h expected v=1 rgb=155", out_valid, {r, g, b}); end
        tick();
    endtask

    task automatic test_blank();
        set_pix(1'b1, 8'hFF, 1'b1);
        tick();
        set_pix(1'b0, 8'hE5, 1'b0);
        tick();
        checks++;
        if ({out_valid, r, g, b} !== {1'b1, 9'h000}) begin errors++; $display("FAIL blank_FF: got v=%b rgb=%h expected v=1 rgb=000", out_valid, {r, g, b}); end
        tick();
        checks++;
        if ({out_valid, r, g, b} !== {1'b0, 9'h000}) begin errors++; $display("FAIL invalid_E5: got v=%b rgb=%h expected v=0 rgb=000", out_valid, {r, g, b}); end
    endtask

    task automatic test_mid_reset();
        int n;
        set_pix(1'b1, 8'h41, 1'b0);
        tick();
        set_pix(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({out_valid, r, g, b} !== {1'b0, 9'h000}) begin errors++; $display("FAIL midreset_drop: got v=%b rgb=%h expected v=0 rgb=000", out_valid, {r, g, b}); end
        checks++;
        if ({init_busy, wr_ready} !== 2'b10) begin errors++; $display("FAIL midreset_flags: got busy=%b ready=%b expected busy=1 ready=0", init_busy, wr_ready); end
        for (int i = 0; i < 100; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_init(n);
        checks++;
        if (n !== 256) begin errors++; $display("FAIL midinit_restart_len: got %0d expected 256", n); end
        set_pix(1'b1, 8'h10, 1'b0);
        tick();
        set_pix(1'b0, 8'h00, 1'b0);
        tick();
        checks++;
        if ({out_valid, r, g, b} !== {1'b1, 9'h020}) begin errors++; $display("FAIL midreset_default_10: got v=%b rgb=%h expected v=1 rgb=020", out_valid, {r, g, b}); end
        tick();
    endtask

`ifdef PALETTE_READBACK_EN
    task automatic test_readback();
        wr_valid = 1'b1;
        wr_addr  = 8'h33;
        wr_data  = 9'h0AB;
        tick();
        wr_valid = 1'b0;
        rd_en    = 1'b1;
        rd_addr  = 8'h33;
        tick();
        rd_en    = 1'b0;
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, 9'h0AB}) begin errors++; $display("FAIL readback_33: got v=%b data=%h expected v=1 data=0ab", rd_valid, rd_data); end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL readback_valid_drop: got %b expected 0", rd_valid); end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        set_pix(1'b0, 8'h00, 1'b0);
        wr_valid  = 1'b0;
        wr_addr   = 8'h00;
        wr_data   = 9'h000;
`ifdef PALETTE_READBACK_EN
        rd_en     = 1'b0;
        rd_addr   = 8'h00;
`endif
        #2;
        test_reset();
        test_init_pixel();
        test_default();
        test_write();
        test_collision();
        test_back_to_back();
        test_blank();
        test_mid_reset();
`ifdef PALETTE_READBACK_EN
        test_readback();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
